// File: rtl/servo_pos_ctrl.sv
// Servo position sequencer: debounced keys step a saturated target, pw_us slews toward it once per PWM frame.
// Optional `SERVO_SWEEP_EN adds sweep_en for a continuous MIN_US<->MAX_US sweep.
module servo_pos_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int MIN_US       = 1000,
    parameter int MAX_US       = 2000,
    parameter int CENTER_US    = 1500,
    parameter int STEP_US      = 100,
    parameter int SLEW_US      = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  key,
    input  logic        frame_done,
`ifdef SERVO_SWEEP_EN
    input  logic        sweep_en,
`endif
    output logic [11:0] pw_us,
    output logic [11:0] target_us,
    output logic        busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic {IDLE = 1'b0, SLEW = 1'b1} state_t;

    state_t           state, state_nx;
    logic [1:0]       key_p0, key_p1;
    logic [1:0]       db_p2, press_p2;
    logic [CNT_W-1:0] cnt_p2 [2];
    logic [11:0]      tgt_nx, pw_nx;

    function automatic logic [11:0] sat_up(input logic [11:0] v);
        logic [12:0] s;
        s = {1'b0, v} + 13'(STEP_US);
        return (s > 13'(MAX_US)) ? 12'(MAX_US) : s[11:0];
    endfunction

    function automatic logic [11:0] sat_dn(input logic [11:0] v);
        logic [12:0] s;
        s = {1'b0, v} - 13'(STEP_US);
        return (s[12] || s < 13'(MIN_US)) ? 12'(MIN_US) : s[11:0];
    endfunction

    function automatic logic [11:0] slew_step(input logic [11:0] cur, input logic [11:0] tgt);
        logic signed [12:0] diff;
        logic signed [12:0] lim;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        lim  = 13'(SLEW_US);
        if (diff > lim)
            return cur + 12'(SLEW_US);
        else if (diff < -lim)
            return cur - 12'(SLEW_US);
        else
            return tgt;
    endfunction

    // stage p0/p1: two-flop key synchronizer
    always_ff @(posedge clk) begin
        key_p0 <= key;
        key_p1 <= key_p0;
    end

    // stage p2: debounce; a press pulses in the cycle the debounced level rises
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_p2     <= '0;
            press_p2  <= '0;
            cnt_p2[0] <= '0;
            cnt_p2[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press_p2[i] <= 1'b0;
                if (key_p1[i] != db_p2[i]) begin
                    if (cnt_p2[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                        db_p2[i]    <= key_p1[i];
                        press_p2[i] <= key_p1[i];
                        cnt_p2[i]   <= '0;
                    end else begin
                        cnt_p2[i] <= cnt_p2[i] + 1'b1;
                    end
                end else begin
                    cnt_p2[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        tgt_nx = target_us;
`ifdef SERVO_SWEEP_EN
        if (sweep_en) begin
            if (state == IDLE)
                tgt_nx = (pw_us <= 12'(CENTER_US)) ? 12'(MAX_US) : 12'(MIN_US);
        end else
`endif
        if (press_p2[0] && !press_p2[1])
            tgt_nx = sat_up(target_us);
        else if (press_p2[1] && !press_p2[0])
            tgt_nx = sat_dn(target_us);
    end

    // stage p3: target, commanded width and slew state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pw_us     <= 12'(CENTER_US);
            target_us <= 12'(CENTER_US);
        end else begin
            state     <= state_nx;
            pw_us     <= pw_nx;
            target_us <= tgt_nx;
        end
    end

    // Stays in SLEW exactly while the registered width and target differ.
    always_comb begin
        state_nx = (tgt_nx != pw_nx) ? SLEW : IDLE;
    end

    // Frame update reads the registered target, so a same-cycle target change waits a frame.
    always_comb begin
        pw_nx = pw_us;
        if (state == SLEW && frame_done)
            pw_nx = slew_step(pw_us, target_us);
    end

    assign busy = (pw_us != target_us);

endmodule
